// File: rtl/pipeline_hazard_controller_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The slave side is the controller; the master side drives the pipeline status.
interface pipeline_hazard_controller_if #(parameter int CNT_W = 16);
   logic             halt, step;
   logic [4:0]       ID_RA, ID_RB;
   logic             ID_RA_USE, ID_RB_USE, ID_BR;
   logic [4:0]       EX_RD, MEM_RD, WB_RD;
   logic             EX_RF_LE, MEM_RF_LE, WB_RF_LE;
   logic             EX_L, EX_BR_TAKEN, EX_NULL;
   logic             PC_LE, IF_ID_LE, IF_ID_CLR, S, TA_SEL;
   logic [1:0]       FWD_A, FWD_B;
   logic [CNT_W-1:0] STALL_CNT, FLUSH_CNT;
   logic [1:0]       STATE;

   modport slave (
      input  halt, step, ID_RA, ID_RB, ID_RA_USE, ID_RB_USE, ID_BR,
             EX_RD, MEM_RD, WB_RD, EX_RF_LE, MEM_RF_LE, WB_RF_LE,
             EX_L, EX_BR_TAKEN, EX_NULL,
      output PC_LE, IF_ID_LE, IF_ID_CLR, S, TA_SEL, FWD_A, FWD_B,
             STALL_CNT, FLUSH_CNT, STATE
   );

   modport master (
      output halt, step, ID_RA, ID_RB, ID_RA_USE, ID_RB_USE, ID_BR,
             EX_RD, MEM_RD, WB_RD, EX_RF_LE, MEM_RF_LE, WB_RF_LE,
             EX_L, EX_BR_TAKEN, EX_NULL,
      input  PC_LE, IF_ID_LE, IF_ID_CLR, S, TA_SEL, FWD_A, FWD_B,
             STALL_CNT, FLUSH_CNT, STATE
   );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Five-stage pipeline hazard control: forwarding selects, load-use stall,
// taken-branch squash with delay-slot nullify, halt/step debug FSM, perf counters.
module pipeline_hazard_controller #(
   parameter int CNT_W = 16
) (
   input logic                         clk,
   input logic                         reset,
   pipeline_hazard_controller_if.slave bus
);
   typedef enum logic [1:0] {RUN = 2'b00, HALT = 2'b01, STEP = 2'b10} state_t;

   state_t           state, state_nxt;
   logic             rst_q;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   logic [1:0][4:0]  src;
   logic [1:0]       src_use, hit_ld;
   logic [1:0][1:0]  fwd;
   logic             lu, safe, taken;
   logic             pc_le, if_id_le, if_id_clr, s, ta_sel;

   assign src     = {bus.ID_RB, bus.ID_RA};
   assign src_use = {bus.ID_RB_USE, bus.ID_RA_USE};
   assign taken   = bus.EX_BR_TAKEN;

   // Per-operand match logic; a live source is a used, non-r0 register.
   for (genvar i = 0; i < 2; i++) begin : g_opnd
      logic live, m_ex, m_mem, m_wb;
      assign live  = src_use[i] && (src[i] != 5'd0);
      assign m_ex  = live && bus.EX_RF_LE && (bus.EX_RD == src[i]);
      assign m_mem = live && bus.MEM_RF_LE && (bus.MEM_RD == src[i]);
      assign m_wb  = live && bus.WB_RF_LE && (bus.WB_RD == src[i]);
      assign hit_ld[i] = m_ex && bus.EX_L;
      assign fwd[i] = (m_ex && !bus.EX_L) ? 2'b01 :
                      m_mem               ? 2'b10 :
                      m_wb                ? 2'b11 : 2'b00;
   end

   assign lu   = |hit_ld;
   assign safe = !bus.ID_BR && !taken && !lu;

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (bus.halt && safe) state_nxt = HALT;
         HALT:    if (!bus.halt) state_nxt = RUN;
                  else if (bus.step) state_nxt = STEP;
         STEP:    if (safe) state_nxt = HALT;
         default: state_nxt = RUN;
      endcase
   end

   // rst_q keeps outputs forced until the first edge that samples reset high.
   always_comb begin
      pc_le     = 1'b1;
      if_id_le  = 1'b1;
      if_id_clr = 1'b0;
      s         = 1'b0;
      ta_sel    = 1'b0;
      if (!rst_q || state == HALT) begin
         pc_le    = 1'b0;
         if_id_le = 1'b0;
         s        = 1'b1;
      end else if (taken) begin
         ta_sel    = 1'b1;
         if_id_clr = 1'b1;
         s         = bus.EX_NULL;
      end else if (lu) begin
         pc_le    = 1'b0;
         if_id_le = 1'b0;
         s        = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      rst_q <= reset;
      if (!reset) begin
         state     <= RUN;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (rst_q) begin
         state <= state_nxt;
         if (state != HALT) begin
            if (taken) begin
               if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
            end else if (lu) begin
               if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
            end
         end
      end
   end

   assign bus.PC_LE     = pc_le;
   assign bus.IF_ID_LE  = if_id_le;
   assign bus.IF_ID_CLR = if_id_clr;
   assign bus.S         = s;
   assign bus.TA_SEL    = ta_sel;
   assign bus.FWD_A     = rst_q ? fwd[0] : 2'b00;
   assign bus.FWD_B     = rst_q ? fwd[1] : 2'b00;
   assign bus.STALL_CNT = stall_cnt;
   assign bus.FLUSH_CNT = flush_cnt;
   assign bus.STATE     = state;
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed plus randomized bench for pipeline_hazard_controller, checked every
// cycle against a rule-level reference model.
module tb_pipeline_hazard_controller;
   localparam int CW   = 4;
   localparam int MAXC = (1 << CW) - 1;

   logic clk = 1'b0;
   logic reset;
   int   total = 0, bad = 0;
   int   m_mode, m_st, m_fl;
   bit   m_rq;

   pipeline_hazard_controller_if #(.CNT_W(CW)) bif ();
   pipeline_hazard_controller #(.CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bif));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // First writer in pipeline order (EX, MEM, WB) whose result is available wins.
   function automatic logic [1:0] m_fwd(input logic [4:0] r, input logic u);
      logic [4:0] rd [3];
      logic       ok [3];
      rd[0] = bif.EX_RD;  ok[0] = bif.EX_RF_LE && !bif.EX_L;
      rd[1] = bif.MEM_RD; ok[1] = bif.MEM_RF_LE;
      rd[2] = bif.WB_RD;  ok[2] = bif.WB_RF_LE;
      if (!u || r == 5'd0) return 2'b00;
      for (int k = 0; k < 3; k++)
         if (ok[k] && rd[k] == r) return 2'(k + 1);
      return 2'b00;
   endfunction

   function automatic bit m_lu();
      if (!(bif.EX_L && bif.EX_RF_LE) || bif.EX_RD == 5'd0) return 0;
      return (bif.ID_RA_USE && bif.ID_RA == bif.EX_RD) ||
             (bif.ID_RB_USE && bif.ID_RB == bif.EX_RD);
   endfunction

   task automatic check_cycle();
      logic pc, ifle, clr, s, ta;
      logic [1:0] fa, fb;
      pc = 1; ifle = 1; clr = 0; s = 0; ta = 0;
      fa = m_fwd(bif.ID_RA, bif.ID_RA_USE);
      fb = m_fwd(bif.ID_RB, bif.ID_RB_USE);
      if (!m_rq) begin
         pc = 0; ifle = 0; s = 1; fa = 0; fb = 0;
      end else if (m_mode == 1) begin
         pc = 0; ifle = 0; s = 1;
      end else if (bif.EX_BR_TAKEN) begin
         ta = 1; clr = 1; s = bif.EX_NULL;
      end else if (m_lu()) begin
         pc = 0; ifle = 0; s = 1;
      end
      chk("PC_LE", bif.PC_LE, pc);
      chk("IF_ID_LE", bif.IF_ID_LE, ifle);
      chk("IF_ID_CLR", bif.IF_ID_CLR, clr);
      chk("S", bif.S, s);
      chk("TA_SEL", bif.TA_SEL, ta);
      chk("FWD_A", bif.FWD_A, fa);
      chk("FWD_B", bif.FWD_B, fb);
      chk("STATE", bif.STATE, m_mode);
      chk("STALL_CNT", bif.STALL_CNT, m_st);
      chk("FLUSH_CNT", bif.FLUSH_CNT, m_fl);
   endtask

   task automatic model_edge();
      bit lu, safe;
      lu   = m_lu();
      safe = !bif.ID_BR && !bif.EX_BR_TAKEN && !lu;
      if (!reset) begin
         m_mode = 0; m_st = 0; m_fl = 0;
      end else if (m_rq) begin
         if (m_mode != 1) begin
            if (bif.EX_BR_TAKEN) m_fl = (m_fl < MAXC) ? m_fl + 1 : MAXC;
            else if (lu)         m_st = (m_st < MAXC) ? m_st + 1 : MAXC;
         end
         case (m_mode)
            0: if (bif.halt && safe) m_mode = 1;
            1: if (!bif.halt) m_mode = 0; else if (bif.step) m_mode = 2;
            default: if (safe) m_mode = 1;
         endcase
      end
      m_rq = reset;
   endtask

   task automatic cyc();
      #1;
      check_cycle();
      model_edge();
      @(negedge clk);
   endtask

   task automatic clear_in();
      bif.halt = 0; bif.step = 0; bif.ID_RA = 0; bif.ID_RB = 0;
      bif.ID_RA_USE = 0; bif.ID_RB_USE = 0; bif.ID_BR = 0;
      bif.EX_RD = 0; bif.MEM_RD = 0; bif.WB_RD = 0;
      bif.EX_RF_LE = 0; bif.MEM_RF_LE = 0; bif.WB_RF_LE = 0;
      bif.EX_L = 0; bif.EX_BR_TAKEN = 0; bif.EX_NULL = 0;
   endtask

   initial begin
      m_mode = 0; m_st = 0; m_fl = 0; m_rq = 0;
      clear_in();
      reset = 0;
      @(negedge clk);
      cyc(); cyc();
      reset = 1;
      cyc();
      cyc();
      chk("rel_state", bif.STATE, 0);

      // load-use on r5, then load in MEM forwards
      bif.EX_L = 1; bif.EX_RF_LE = 1; bif.EX_RD = 5; bif.ID_RA = 5; bif.ID_RA_USE = 1;
      cyc();
      chk("lu_cnt", bif.STALL_CNT, 1);
      bif.EX_L = 0; bif.EX_RF_LE = 0; bif.EX_RD = 0; bif.MEM_RD = 5; bif.MEM_RF_LE = 1;
      cyc();

      // taken branches without and with nullify
      clear_in();
      bif.EX_BR_TAKEN = 1; bif.EX_NULL = 0; cyc();
      bif.EX_NULL = 1; cyc();
      clear_in();
      chk("flush_cnt", bif.FLUSH_CNT, 2);
      cyc();

      // forwarding priority on RB
      bif.EX_RD = 7; bif.MEM_RD = 7; bif.WB_RD = 7;
      bif.EX_RF_LE = 1; bif.MEM_RF_LE = 1; bif.WB_RF_LE = 1;
      bif.ID_RB = 7; bif.ID_RB_USE = 1;
      cyc();
      bif.EX_RF_LE = 0; cyc();
      bif.ID_RB = 0; cyc();
      clear_in();

      // halt deferred behind branch, then single step
      bif.halt = 1; bif.ID_BR = 1; cyc(); cyc();
      bif.ID_BR = 0; cyc();
      chk("halt_state", bif.STATE, 1);
      cyc();
      bif.step = 1; cyc();
      bif.step = 0;
      chk("step_state", bif.STATE, 2);
      #1 chk("step_pc", bif.PC_LE, 1);
      cyc();
      chk("post_step", bif.STATE, 1);
      bif.halt = 0; cyc();
      chk("resume", bif.STATE, 0);

      // saturation via long load-use run
      bif.EX_L = 1; bif.EX_RF_LE = 1; bif.EX_RD = 9; bif.ID_RB = 9; bif.ID_RB_USE = 1;
      for (int i = 0; i < 20; i++) cyc();
      chk("sat", bif.STALL_CNT, MAXC);

      // reset mid-stall
      reset = 0; cyc();
      chk("rst_cnt", bif.STALL_CNT, 0);
      cyc();
      reset = 1; cyc(); cyc();
      clear_in();

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         bif.ID_RA = 5'($urandom_range(0, 7));
         bif.ID_RB = 5'($urandom_range(0, 7));
         bif.ID_RA_USE = 1'($urandom_range(0, 1));
         bif.ID_RB_USE = 1'($urandom_range(0, 1));
         bif.ID_BR = ($urandom_range(0, 4) == 0);
         bif.EX_RD = 5'($urandom_range(0, 7));
         bif.MEM_RD = 5'($urandom_range(0, 7));
         bif.WB_RD = 5'($urandom_range(0, 7));
         bif.EX_RF_LE = 1'($urandom_range(0, 1));
         bif.MEM_RF_LE = 1'($urandom_range(0, 1));
         bif.WB_RF_LE = 1'($urandom_range(0, 1));
         bif.EX_BR_TAKEN = ($urandom_range(0, 5) == 0);
         bif.EX_NULL = 1'($urandom_range(0, 1));
         bif.EX_L = bif.EX_BR_TAKEN ? 1'b0 : ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 9) == 0) bif.halt = ~bif.halt;
         bif.step = ($urandom_range(0, 3) == 0);
         reset = ($urandom_range(0, 59) != 0);
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
